// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and line-level constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int PRESC_MIN = 4;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Per-bit edge counter for the UART transmitter.
// Prescale is captured on load and clamped to a minimum of 4.
module uart_tx_baud_cnt
    import uart_pkg::*;
#(
    parameter int PRESCALE_MAX = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          cnt_en,
    input  logic [$clog2(PRESCALE_MAX):0] prescale,
    output logic                          bit_done
);

    localparam int PW = $clog2(PRESCALE_MAX) + 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] presc_clamped;

    assign presc_clamped = (prescale < PW'(PRESC_MIN))
                         ? PW'(PRESC_MIN) : prescale;

    assign bit_done = cnt_en && (cnt_q == (presc_q - PW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= PW'(PRESC_MIN);
            cnt_q   <= '0;
        end else if (load) begin
            presc_q <= presc_clamped;
            cnt_q   <= '0;
        end else if (cnt_en) begin
            cnt_q <= bit_done ? '0 : cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PRESCALE_MAX = 32,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(PRESCALE_MAX):0] Prescale,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          Data_Valid,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    output logic                          TX_OUT,
    output logic                          Busy
);

    localparam int IW = $clog2(DATA_WIDTH);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  load;
    logic                  cnt_en;
    logic                  bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_bit;

    assign par_bit = (^data_q) ^ (par_typ_q == PAR_ODD);
`else
    logic unused_par;

    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    assign cnt_en = (state_q != TX_IDLE);
    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    uart_tx_baud_cnt #(
        .PRESCALE_MAX(PRESCALE_MAX)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .cnt_en  (cnt_en),
        .prescale(Prescale),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        unique case (state_q)
            TX_IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    load    = 1'b1;
                    data_d  = P_DATA;
                    state_d = TX_START;
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = TX_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = STOP_BIT;
                        end
`else
                        state_d = TX_STOP;
                        tx_d    = STOP_BIT;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                        tx_d  = data_q[idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_done) begin
                    state_d = TX_STOP;
                    tx_d    = STOP_BIT;
                end
            end
`endif
            TX_STOP: begin
                if (bit_done) begin
                    state_d = TX_IDLE;
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table plus scoreboarded
// frame monitor; expected frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        int         presc;
        logic [7:0] data;
        bit         pe;
        bit         pt;
        bit         exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         par_on;
        bit         par_bit;
        int         presc;
        int         start;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_off = 1'b1;
    bit   checking = 1'b0;
    bit   prev_tx = 1'b1;
    rec_t sb[$];
    vec_t vecs[7];

    uart_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int eff_presc(input int p);
        return (p < 4) ? 4 : p;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (Busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || checking) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 5000), 32'd1);
    endtask

    task automatic send(input int p, input logic [7:0] d,
                        input bit pe, input bit pt, input bit ep,
                        input bit push, output int st);
        rec_t r;
        wait_idle();
        Prescale   = 6'(p);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        st = cyc + 1;
        if (push) begin
            r.data    = d;
            r.par_on  = PAR_BUILD && pe;
            r.par_bit = ep;
            r.presc   = eff_presc(p);
            r.start   = st;
            sb.push_back(r);
        end
        @(negedge clk);
        Data_Valid = 1'b0;
    endtask

    task automatic check_frame();
        rec_t r;
        int   n;
        bit   bits[11];
        bit   bad;
        bit   bad_busy;
        logic got;
        checking = 1'b1;
        if (sb.size() == 0) begin
            chk("unexpected_start", 32'd1, 32'd0);
            checking = 1'b0;
            return;
        end
        r = sb.pop_front();
        chk("start_cycle", 32'(cyc), 32'(r.start));
        n = r.par_on ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = r.data[i];
        if (r.par_on) bits[9] = r.par_bit;
        bits[n-1] = 1'b1;
        bad_busy = 1'b0;
        for (int k = 0; k < n; k++) begin
            bad = 1'b0;
            got = bits[k];
            for (int c = 0; c < r.presc; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (TX_OUT !== bits[k] && !bad) begin
                    bad = 1'b1;
                    got = TX_OUT;
                end
                if (Busy !== 1'b1) bad_busy = 1'b1;
            end
            chk($sformatf("frame_%0h_bit%0d", r.data, k),
                32'(got), 32'(bits[k]));
        end
        chk("busy_in_frame", 32'(bad_busy), 32'd0);
        @(negedge clk);
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_tx", 32'(TX_OUT), 32'd1);
        checking = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_off && prev_tx && TX_OUT === 1'b0) check_frame();
            prev_tx = TX_OUT;
        end
    end

    initial begin
        int   st;
        int   c0;
        int   nf;
        bit   bad;
        rec_t r;

        vecs[0] = '{8,  8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8,  8'h01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8,  8'h03, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{16, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4,  8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32, 8'hC3, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{2,  8'h80, 1'b1, 1'b0, 1'b1};

        #1 rst_n = 1'b0;
        #2;
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_off = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].presc, vecs[i].data, vecs[i].pe,
                 vecs[i].pt, vecs[i].exp_par, 1'b1, st);
        end
        drain();

        // prescale and payload change mid-frame must not disturb it
        send(8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, st);
        repeat (19) @(negedge clk);
        Prescale = 6'd4;
        P_DATA   = 8'h00;
        PAR_EN   = 1'b1;
        send(4, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, st);
        drain();

        // Data_Valid held high: back-to-back frames
        wait_idle();
        c0 = cyc;
        nf = PAR_BUILD ? 11 : 10;
        Prescale   = 6'd8;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        r.data    = 8'h3C;
        r.par_on  = PAR_BUILD;
        r.par_bit = ^r.data;
        r.presc   = 8;
        r.start   = c0 + 1;
        sb.push_back(r);
        r.data    = 8'h81;
        r.par_bit = ^r.data;
        r.start   = c0 + 1 + nf * 8 + 1;
        sb.push_back(r);
        repeat (20) @(negedge clk);
        P_DATA = 8'h81;
        repeat (75) @(negedge clk);
        Data_Valid = 1'b0;
        drain();

        // asynchronous reset during data bit 3
        mon_off = 1'b1;
        send(8, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, st);
        repeat (35) @(negedge clk);
        chk("rst_pre_bit3", 32'(TX_OUT), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 32'(TX_OUT), 32'd1);
        chk("rst_async_busy", 32'(Busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_off = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) bad = 1'b1;
        end
        chk("idle_after_rst", 32'(bad), 32'd0);
        send(8, 8'hE7, 1'b1, 1'b1, 1'b1, 1'b1, st);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
